game_controller: RTL and testbench
==================================

# game_controller

Sequential game-flow controller sitting upstream of the attack/display path in the naval-battle top level. It owns the game state (idle, preparation, attack, game over) and drives `game_state_code` into the state decoder. During attack it resolves each debounced confirm pulse against the committed map, and keeps shot/hit masks and remaining-shot/remaining-ship counters. It also drives the RGB feedback LED and win/lose result, replacing the free-running switch-selected state code.

## Interface
- `MAP_WIDTH`, 35, map bits; bit index = x*COLUNE_SIZE + y
- `COLUNE_SIZE`, 7, rows per column; valid y = 0..6
- `TOTAL_COLUNES`, 5, columns; valid x = 0..4
- `MAX_SHOTS`, 20, shots granted per game
- `SHOT_WIDTH`, 5, width of shot counter; must hold MAX_SHOTS

- `clk`  in  1  divided system clock (output of freq_div); all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  debounced single-cycle pulse; advances/commits/restarts the game
- `confirmAttack`  in  1  debounced single-cycle pulse; fire at current coordinates
- `x_coord_code`  in  3  target column
- `y_coord_code`  in  3  target row
- `selected_map`  in  MAP_WIDTH  ship map from map_decoder, 1 = ship cell
- `game_state_code`  out  2  00 IDLE, 01 PREP, 10 ATTACK, 11 OVER
- `shot_mask`  out  MAP_WIDTH  1 = cell already fired on
- `hit_mask`  out  MAP_WIDTH  1 = ship cell hit
- `shots_left`  out  SHOT_WIDTH  remaining shots
- `hits_left`  out  6  ship cells not yet hit
- `ledRgb`  out  3  {r,g,b} feedback of last event
- `win`  out  1  valid in OVER: 1 = all ships sunk
- `attack_done`  out  1  one-cycle pulse per consumed shot

## Operation
- Reset (async assert, sync to edge on release): state IDLE; masks, counters, `ledRgb`, `win`, `attack_done` all 0.
- IDLE: `start` -> PREP. `confirmAttack` ignored.
- PREP: map chosen externally. On `start`, compute popcount(`selected_map`):
  - popcount = 0: stay PREP, `ledRgb` = 101.
  - popcount > 0: latch popcount into `hits_left`, `shots_left` <= MAX_SHOTS, clear masks, `ledRgb` <= 000, go ATTACK. Map is not latched; map_code must stay stable outside PREP (reset tie to enable already guarantees this).
  - `confirmAttack` ignored.
- ATTACK, on `confirmAttack`, with idx = x*7+y:
  - x > 4 or y > 6: invalid; no counter/mask change, `ledRgb` = 101, no `attack_done`.
  - `shot_mask[idx]` = 1: repeat; no change, `ledRgb` = 001, no `attack_done`.
  - Otherwise: set `shot_mask[idx]`, decrement `shots_left`, pulse `attack_done`.
    - `selected_map[idx]` = 1: set `hit_mask[idx]`, decrement `hits_left`, `ledRgb` = 010.
    - Else: `ledRgb` = 100.
  - After the shot, if new `hits_left` = 0: `win` <= 1, go OVER. Else if new `shots_left` = 0: `win` <= 0, go OVER. Win has priority when both reach 0 on the same shot.
  - `start` ignored in ATTACK; there is no abort.
- OVER: masks and counters frozen. `ledRgb` = 010 if `win`, else 100. `start` -> IDLE, clearing masks, counters and `win`.
- Counters never wrap. Decrements occur only on consumed shots, which are impossible at 0 because OVER is entered first.

## Timing
- All outputs registered. Pulse sampled at edge n gives all updates (state, masks, counters, LED, `attack_done`) visible after edge n: latency 1.
- `attack_done` high for exactly the cycle following the consuming edge.
- Popcount and coordinate decode are combinational, within one `clk` period.
- `start` and `confirmAttack` in the same cycle: state-specific rule above applies; only one event acts per state.
- Back-to-back confirm pulses on consecutive cycles are each processed.
- Reset asserted mid-ATTACK clears everything immediately, independent of `clk`.

## Test plan
- Reset then `start` ×2 with a 3-ship map -> codes 00 -> 01 -> 10; `hits_left` = 3, `shots_left` = 20, masks 0.
- In ATTACK, fire at a ship cell (x=1, y=2, idx 9) -> `shot_mask[9]` = `hit_mask[9]` = 1, `hits_left` = 2, `shots_left` = 19, `ledRgb` = 010, one `attack_done` pulse.
- Fire the same cell again, then x=5 y=0 -> no counter change, `ledRgb` = 001 then 101, no `attack_done`.
- Sink all 3 ships -> code 11, `win` = 1, `ledRgb` = 010; further confirms ignored; `start` -> 00 with all cleared.
- Fire 20 misses on a 1-ship map -> after the 20th, code 11, `win` = 0, `shots_left` = 0, `ledRgb` = 100. Also fire the last ship cell on the last shot -> `win` = 1.
- `start` in PREP with an all-zero map -> stays 01, `ledRgb` = 101. Drop `reset` low mid-ATTACK -> code 00 and all outputs 0 immediately.

Source files
------------

// File: rtl/game_controller.sv
// Naval-battle game-flow controller: idle/prep/attack/over FSM that
// resolves confirm pulses against the ship map and tracks shots, hits and result.
//
// Ports:
//   clk, reset (async, active-low)
//   start, confirmAttack         : single-cycle debounced pulses
//   x_coord_code, y_coord_code   : target column / row
//   selected_map                 : ship map, 1 = ship cell, bit = x*COLUNE_SIZE+y
//   game_state_code              : 00 IDLE, 01 PREP, 10 ATTACK, 11 OVER
//   shot_mask, hit_mask          : fired cells / hit ship cells
//   shots_left, hits_left        : remaining shots / unhit ship cells
//   ledRgb                       : {r,g,b} feedback of the last event
//   win                          : result, meaningful in OVER
//   attack_done                  : one-cycle pulse per consumed shot
module game_controller #(
  parameter int MAP_WIDTH     = 35,
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int MAX_SHOTS     = 20,
  parameter int SHOT_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  confirmAttack,
  input  logic [2:0]            x_coord_code,
  input  logic [2:0]            y_coord_code,
  input  logic [MAP_WIDTH-1:0]  selected_map,
  output logic [1:0]            game_state_code,
  output logic [MAP_WIDTH-1:0]  shot_mask,
  output logic [MAP_WIDTH-1:0]  hit_mask,
  output logic [SHOT_WIDTH-1:0] shots_left,
  output logic [5:0]            hits_left,
  output logic [2:0]            ledRgb,
  output logic                  win,
  output logic                  attack_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_ATK  = 2'b10,
    S_OVER = 2'b11
  } state_t;

  localparam logic [2:0] LED_OFF  = 3'b000;
  localparam logic [2:0] LED_BAD  = 3'b101;
  localparam logic [2:0] LED_REP  = 3'b001;
  localparam logic [2:0] LED_HIT  = 3'b010;
  localparam logic [2:0] LED_MISS = 3'b100;

  localparam logic [2:0] X_LIM = 3'(TOTAL_COLUNES);
  localparam logic [2:0] Y_LIM = 3'(COLUNE_SIZE);
  localparam logic [SHOT_WIDTH-1:0] SHOTS_INIT =
    SHOT_WIDTH'(MAX_SHOTS);
  localparam logic [SHOT_WIDTH-1:0] SHOT_ONE =
    SHOT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [MAP_WIDTH-1:0]   shot_q, shot_d;
  logic [MAP_WIDTH-1:0]   hit_q, hit_d;
  logic [SHOT_WIDTH-1:0]  shots_q, shots_d;
  logic [5:0]             hits_q, hits_d;
  logic [2:0]             led_q, led_d;
  logic                   win_q, win_d;
  logic                   done_q, done_d;

  logic [5:0]             ship_cnt;
  logic [5:0]             idx;
  logic                   coord_ok;

  function automatic logic [5:0] popcnt(
    input logic [MAP_WIDTH-1:0] m
  );
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MAP_WIDTH; i++)
      c = c + {5'b0, m[i]};
    return c;
  endfunction

  assign ship_cnt = popcnt(selected_map);
  assign coord_ok = (x_coord_code < X_LIM) &&
                    (y_coord_code < Y_LIM);
  assign idx = 6'(x_coord_code) * 6'(COLUNE_SIZE)
             + 6'(y_coord_code);

  always_comb begin
    state_d = state_q;
    shot_d  = shot_q;
    hit_d   = hit_q;
    shots_d = shots_q;
    hits_d  = hits_q;
    led_d   = led_q;
    win_d   = win_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PREP;
      end
      S_PREP: begin
        if (start) begin
          if (ship_cnt == 6'd0) begin
            led_d = LED_BAD;
          end else begin
            hits_d  = ship_cnt;
            shots_d = SHOTS_INIT;
            shot_d  = '0;
            hit_d   = '0;
            led_d   = LED_OFF;
            state_d = S_ATK;
          end
        end
      end
      S_ATK: begin
        if (confirmAttack) begin
          if (!coord_ok) begin
            led_d = LED_BAD;
          end else if (shot_q[idx]) begin
            led_d = LED_REP;
          end else begin
            shot_d[idx] = 1'b1;
            shots_d     = shots_q - SHOT_ONE;
            done_d      = 1'b1;
            if (selected_map[idx]) begin
              hit_d[idx] = 1'b1;
              hits_d     = hits_q - 6'd1;
              led_d      = LED_HIT;
            end else begin
              led_d = LED_MISS;
            end
            // Sinking the last ship wins even on the final shot.
            if (hits_d == 6'd0) begin
              win_d   = 1'b1;
              led_d   = LED_HIT;
              state_d = S_OVER;
            end else if (shots_d == '0) begin
              win_d   = 1'b0;
              led_d   = LED_MISS;
              state_d = S_OVER;
            end
          end
        end
      end
      S_OVER: begin
        led_d = win_q ? LED_HIT : LED_MISS;
        if (start) begin
          shot_d  = '0;
          hit_d   = '0;
          shots_d = '0;
          hits_d  = '0;
          win_d   = 1'b0;
          led_d   = LED_OFF;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shot_q  <= '0;
      hit_q   <= '0;
      shots_q <= '0;
      hits_q  <= '0;
      led_q   <= LED_OFF;
      win_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shot_q  <= shot_d;
      hit_q   <= hit_d;
      shots_q <= shots_d;
      hits_q  <= hits_d;
      led_q   <= led_d;
      win_q   <= win_d;
      done_q  <= done_d;
    end
  end

  assign game_state_code = state_q;
  assign shot_mask       = shot_q;
  assign hit_mask        = hit_q;
  assign shots_left      = shots_q;
  assign hits_left       = hits_q;
  assign ledRgb          = led_q;
  assign win             = win_q;
  assign attack_done     = done_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed steps, reference
// model results queued at drive time and popped after each clock edge.
module tb_game_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        confirmAttack;
  logic [2:0]  x_coord_code;
  logic [2:0]  y_coord_code;
  logic [34:0] selected_map;
  logic [1:0]  game_state_code;
  logic [34:0] shot_mask;
  logic [34:0] hit_mask;
  logic [4:0]  shots_left;
  logic [5:0]  hits_left;
  logic [2:0]  ledRgb;
  logic        win;
  logic        attack_done;

  game_controller dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .confirmAttack   (confirmAttack),
    .x_coord_code    (x_coord_code),
    .y_coord_code    (y_coord_code),
    .selected_map    (selected_map),
    .game_state_code (game_state_code),
    .shot_mask       (shot_mask),
    .hit_mask        (hit_mask),
    .shots_left      (shots_left),
    .hits_left       (hits_left),
    .ledRgb          (ledRgb),
    .win             (win),
    .attack_done     (attack_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [34:0] sm;
    logic [34:0] hm;
    logic [4:0]  sl;
    logic [5:0]  hl;
    logic [2:0]  led;
    logic        win;
    logic        ad;
  } snap_t;

  snap_t sb[$];
  int tests = 0;
  int fails = 0;

  logic [1:0]  m_st;
  logic [34:0] m_sm, m_hm;
  logic [4:0]  m_sl;
  logic [5:0]  m_hl;
  logic [2:0]  m_led;
  logic        m_win, m_ad;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 2'b00; m_sm = '0; m_hm = '0; m_sl = '0;
    m_hl = '0; m_led = 3'b000; m_win = 1'b0; m_ad = 1'b0;
  endtask

  task automatic push();
    snap_t s;
    s.st = m_st; s.sm = m_sm; s.hm = m_hm; s.sl = m_sl;
    s.hl = m_hl; s.led = m_led; s.win = m_win; s.ad = m_ad;
    sb.push_back(s);
  endtask

  task automatic compare(input string tag);
    snap_t e;
    if (sb.size() == 0) begin
      chk({tag, ".queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".state"}, 64'(game_state_code), 64'(e.st));
      chk({tag, ".shot_mask"}, 64'(shot_mask), 64'(e.sm));
      chk({tag, ".hit_mask"}, 64'(hit_mask), 64'(e.hm));
      chk({tag, ".shots_left"}, 64'(shots_left), 64'(e.sl));
      chk({tag, ".hits_left"}, 64'(hits_left), 64'(e.hl));
      chk({tag, ".led"}, 64'(ledRgb), 64'(e.led));
      chk({tag, ".win"}, 64'(win), 64'(e.win));
      chk({tag, ".attack_done"}, 64'(attack_done), 64'(e.ad));
    end
  endtask

  // Behavioural reference of one clock edge with the given inputs.
  task automatic model_step(input bit s, input bit c,
                            input int x, input int y);
    int idx;
    m_ad = 1'b0;
    case (m_st)
      2'b00: if (s) m_st = 2'b01;
      2'b01: if (s) begin
        if ($countones(selected_map) == 0) m_led = 3'b101;
        else begin
          m_hl = 6'($countones(selected_map));
          m_sl = 5'd20; m_sm = '0; m_hm = '0;
          m_led = 3'b000; m_st = 2'b10;
        end
      end
      2'b10: if (c) begin
        if (x > 4 || y > 6) m_led = 3'b101;
        else begin
          idx = x * 7 + y;
          if (m_sm[idx]) m_led = 3'b001;
          else begin
            m_sm[idx] = 1'b1; m_sl = m_sl - 5'd1; m_ad = 1'b1;
            if (selected_map[idx]) begin
              m_hm[idx] = 1'b1; m_hl = m_hl - 6'd1; m_led = 3'b010;
            end else m_led = 3'b100;
            if (m_hl == 0) begin
              m_win = 1'b1; m_st = 2'b11; m_led = 3'b010;
            end else if (m_sl == 0) begin
              m_win = 1'b0; m_st = 2'b11; m_led = 3'b100;
            end
          end
        end
      end
      default: begin
        m_led = m_win ? 3'b010 : 3'b100;
        if (s) begin
          m_st = 2'b00; m_sm = '0; m_hm = '0; m_sl = '0;
          m_hl = '0; m_win = 1'b0; m_led = 3'b000;
        end
      end
    endcase
  endtask

  task automatic step(input string tag, input bit s, input bit c,
                      input int x, input int y);
    @(negedge clk);
    start = s; confirmAttack = c;
    x_coord_code = 3'(x); y_coord_code = 3'(y);
    model_step(s, c, x, y);
    push();
    @(posedge clk);
    #1;
    start = 1'b0; confirmAttack = 1'b0;
    compare(tag);
  endtask

  logic [34:0] map3, map1;

  initial begin
    map3 = 35'd0;
    map3[0] = 1'b1; map3[9] = 1'b1; map3[20] = 1'b1;
    map1 = 35'd0;
    map1[34] = 1'b1;

    reset = 1'b0; start = 1'b0; confirmAttack = 1'b0;
    x_coord_code = 3'd0; y_coord_code = 3'd0;
    selected_map = map3;
    model_reset();
    push();
    #3;
    compare("reset");
    @(negedge clk);
    reset = 1'b1;

    step("idle_confirm", 1'b0, 1'b1, 0, 0);
    step("to_prep", 1'b1, 1'b0, 0, 0);
    step("to_attack", 1'b1, 1'b0, 0, 0);
    chk("attack_hits3", 64'(hits_left), 64'd3);
    chk("attack_shots20", 64'(shots_left), 64'd20);

    step("hit_x1y2", 1'b0, 1'b1, 1, 2);
    chk("hit_led", 64'(ledRgb), 64'b010);
    chk("hit_done", 64'(attack_done), 64'd1);
    step("idle_after_hit", 1'b0, 1'b0, 0, 0);
    chk("done_drops", 64'(attack_done), 64'd0);
    step("repeat", 1'b0, 1'b1, 1, 2);
    chk("repeat_led", 64'(ledRgb), 64'b001);
    step("bad_x5", 1'b0, 1'b1, 5, 0);
    chk("bad_led", 64'(ledRgb), 64'b101);
    step("bad_y7", 1'b0, 1'b1, 0, 7);
    step("start_in_attack", 1'b1, 1'b0, 3, 3);
    step("start_and_miss", 1'b1, 1'b1, 3, 3);
    step("hit_idx0", 1'b0, 1'b1, 0, 0);
    step("hit_idx20_win", 1'b0, 1'b1, 2, 6);
    chk("win_state", 64'(game_state_code), 64'b11);
    chk("win_flag", 64'(win), 64'd1);
    step("over_hold", 1'b0, 1'b0, 0, 0);
    step("over_confirm", 1'b0, 1'b1, 4, 4);
    step("over_to_idle", 1'b1, 1'b0, 0, 0);

    selected_map = 35'd0;
    step("prep_again", 1'b1, 1'b0, 0, 0);
    step("prep_empty", 1'b1, 1'b0, 0, 0);
    chk("empty_state", 64'(game_state_code), 64'b01);
    chk("empty_led", 64'(ledRgb), 64'b101);
    selected_map = map1;
    step("attack_map1", 1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 20; i++)
      step($sformatf("miss%0d", i), 1'b0, 1'b1, i / 7, i % 7);
    chk("lose_state", 64'(game_state_code), 64'b11);
    chk("lose_win", 64'(win), 64'd0);
    chk("lose_shots", 64'(shots_left), 64'd0);
    chk("lose_led", 64'(ledRgb), 64'b100);
    step("lose_to_idle", 1'b1, 1'b0, 0, 0);

    step("g3_prep", 1'b1, 1'b0, 0, 0);
    step("g3_attack", 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 19; i++)
      step($sformatf("g3_miss%0d", i), 1'b0, 1'b1, i / 7, i % 7);
    step("g3_last_hit", 1'b0, 1'b1, 4, 6);
    chk("last_shot_win", 64'(win), 64'd1);
    chk("last_shot_left", 64'(shots_left), 64'd0);
    step("g3_to_idle", 1'b1, 1'b0, 0, 0);

    selected_map = map3;
    step("g4_prep", 1'b1, 1'b0, 0, 0);
    step("g4_attack", 1'b1, 1'b0, 0, 0);
    step("g4_hit", 1'b0, 1'b1, 1, 2);
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    push();
    #1;
    compare("async_reset");
    @(negedge clk);
    reset = 1'b1;
    step("post_reset_idle", 1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
